// File: rtl/adpll_lock_detect_if.sv
// ----------------------------------------------------------------------------
// adpll_lock_detect_if
//   Signal bundle between the loop core (master) and the lock detector
//   (slave). clk and rst_n are not part of the bundle.
//
//   master drives : clk_ref, clr, err_mag, err_sign, lock_thr, lock_n
//   slave drives  : sample_stb, locked, lock_state, ref_lost, slip_cnt
//
//   Handshake: sample_stb behaves as a valid with no ready. The detector
//   raises it for exactly one clk cycle per reference edge, reads
//   err_mag/lock_thr/lock_n in that cycle only, and the master cannot stall
//   it; the status outputs carry the result of that sample from the next
//   cycle onwards.
// ----------------------------------------------------------------------------
interface adpll_lock_detect_if;
  logic       clk_ref;
  logic       clr;
  logic [4:0] err_mag;
  logic       err_sign;
  logic [4:0] lock_thr;
  logic [3:0] lock_n;
  logic       sample_stb;
  logic       locked;
  logic [1:0] lock_state;
  logic       ref_lost;
  logic [7:0] slip_cnt;

  modport master (
    output clk_ref, clr, err_mag, err_sign, lock_thr, lock_n,
    input  sample_stb, locked, lock_state, ref_lost, slip_cnt
  );

  modport slave (
    input  clk_ref, clr, err_mag, err_sign, lock_thr, lock_n,
    output sample_stb, locked, lock_state, ref_lost, slip_cnt
  );
endinterface

// File: rtl/adpll_lock_detect.sv
// ----------------------------------------------------------------------------
// adpll_lock_detect
//   Lock detector for the ADPLL. Each clk_ref rising edge (synchronized into
//   clk) produces one sample of the loop-filter phase error; consecutive
//   in-window samples acquire lock, consecutive out-of-window samples drop it,
//   and a missing reference forces the detector back to UNLOCKED.
//
//   Ports
//     clk    : sampling clock (loop core clock)
//     rst_n  : asynchronous active-low reset
//     bus    : adpll_lock_detect_if.slave
//              in  : clk_ref, clr, err_mag[4:0], err_sign, lock_thr[4:0],
//                    lock_n[3:0]
//              out : sample_stb, locked, lock_state[1:0], ref_lost,
//                    slip_cnt[7:0]
//
//   lock_state doubles as the FSM debug view:
//     UNLOCKED=00, ACQUIRE=01, LOCKED=10, HOLD=11
// ----------------------------------------------------------------------------
module adpll_lock_detect #(
  parameter int UNLOCK_N = 4,     // 1..15
  parameter int TIMEOUT  = 1024   // 2..65535
) (
  input  logic              clk,
  input  logic              rst_n,
  adpll_lock_detect_if.slave bus
);

  typedef enum logic [1:0] {
    ST_UNLOCKED = 2'b00,
    ST_ACQUIRE  = 2'b01,
    ST_LOCKED   = 2'b10,
    ST_HOLD     = 2'b11
  } state_t;

  localparam logic [3:0]  UNLOCK_C   = 4'(UNLOCK_N);
  localparam logic [15:0] TIMEOUT_C  = 16'(TIMEOUT);
  localparam logic [15:0] TIMEOUT_M1 = 16'(TIMEOUT - 1);

  logic [2:0]  sync_q;   // [0],[1] synchronizer, [2] history of [1]
  logic        stb_q;
  logic [15:0] idle_q;
  logic        timeout_hit;
  state_t      state_q, state_d;
  logic [3:0]  good_q, good_d;
  logic [3:0]  bad_q, bad_d;
  logic        lost_q, lost_d;
  logic [7:0]  slip_q;
  logic        slip_inc;
  logic        in_win;
  logic [3:0]  n_eff;
  logic [4:0]  good_inc;
  logic [4:0]  bad_inc;
  logic        unused_sign;

  // The sign is carried on the bus for observability only.
  assign unused_sign = bus.err_sign;

  // Reference edge detect. The strobe is registered, so it appears in the
  // third cycle after the first edge that samples clk_ref=1. clr does not
  // touch these flops so an edge in flight is never lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= 3'b000;
      stb_q  <= 1'b0;
    end else begin
      sync_q <= {sync_q[1:0], bus.clk_ref};
      stb_q  <= sync_q[1] & ~sync_q[2];
    end
  end

  // Idle counter saturates at TIMEOUT; the timeout event is the single edge
  // on which it arrives there, so a later strobe is never masked by it.
  assign timeout_hit = !stb_q && (idle_q == TIMEOUT_M1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idle_q <= 16'd0;
    end else if (bus.clr || stb_q) begin
      idle_q <= 16'd0;
    end else if (idle_q != TIMEOUT_C) begin
      idle_q <= idle_q + 16'd1;
    end
  end

  assign in_win   = (bus.err_mag <= bus.lock_thr);
  assign n_eff    = (bus.lock_n == 4'd0) ? 4'd1 : bus.lock_n;
  assign good_inc = {1'b0, good_q} + 5'd1;
  assign bad_inc  = {1'b0, bad_q} + 5'd1;

  // FSM: state register and counters
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_UNLOCKED;
      good_q  <= 4'd0;
      bad_q   <= 4'd0;
      lost_q  <= 1'b0;
      slip_q  <= 8'd0;
    end else begin
      state_q <= state_d;
      good_q  <= good_d;
      bad_q   <= bad_d;
      lost_q  <= lost_d;
      if (bus.clr) begin
        slip_q <= 8'd0;
      end else if (slip_inc && (slip_q != 8'hFF)) begin
        slip_q <= slip_q + 8'd1;
      end
    end
  end

  // FSM: next state. Priority clr > timeout > sample.
  // Lock compares use >= so that lowering lock_n while acquiring locks on
  // the next good sample even if good_cnt already exceeds the new N.
  always_comb begin
    state_d  = state_q;
    good_d   = good_q;
    bad_d    = bad_q;
    lost_d   = lost_q;
    slip_inc = 1'b0;
    if (bus.clr) begin
      state_d = ST_UNLOCKED;
      good_d  = 4'd0;
      bad_d   = 4'd0;
      lost_d  = 1'b0;
    end else if (timeout_hit) begin
      state_d  = ST_UNLOCKED;
      good_d   = 4'd0;
      bad_d    = 4'd0;
      lost_d   = 1'b1;
      slip_inc = state_q[1];
    end else if (stb_q) begin
      lost_d = 1'b0;
      case (state_q)
        ST_UNLOCKED, ST_ACQUIRE: begin
          if (!in_win) begin
            state_d = ST_UNLOCKED;
            good_d  = 4'd0;
          end else if (good_inc >= {1'b0, n_eff}) begin
            state_d = ST_LOCKED;
            good_d  = 4'd0;
            bad_d   = 4'd0;
          end else begin
            state_d = ST_ACQUIRE;
            good_d  = good_inc[3:0];
          end
        end
        ST_LOCKED, ST_HOLD: begin
          if (in_win) begin
            state_d = ST_LOCKED;
            bad_d   = 4'd0;
          end else if (bad_inc >= {1'b0, UNLOCK_C}) begin
            state_d  = ST_UNLOCKED;
            bad_d    = 4'd0;
            good_d   = 4'd0;
            slip_inc = 1'b1;
          end else begin
            state_d = ST_HOLD;
            bad_d   = bad_inc[3:0];
          end
        end
        default: state_d = ST_UNLOCKED;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    bus.sample_stb = stb_q;
    bus.locked     = state_q[1];
    bus.lock_state = state_q;
    bus.ref_lost   = lost_q;
    bus.slip_cnt   = slip_q;
  end

endmodule

// File: tb/tb_adpll_lock_detect.sv
module tb_adpll_lock_detect;

  localparam int UNLOCK_N = 4;
  localparam int TIMEOUT  = 1024;

  // ---------------- clock / reset ----------------
  logic clk   = 1'b0;
  logic rst_n = 1'b0;
  always #10 clk = ~clk;

  adpll_lock_detect_if bus();

  adpll_lock_detect #(.UNLOCK_N(UNLOCK_N), .TIMEOUT(TIMEOUT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial begin
    #(20 * 60000);
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- scoreboard state ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];   // {ref_lost, slip_cnt, locked, lock_state}

  // Reference model: lock is a run of in-window samples since the last
  // unlock; loss of lock is a run of UNLOCK_N misses while locked.
  bit m_locked;
  int m_good;   // in-window run while unlocked
  int m_bad;    // out-of-window run while locked
  int m_slip;
  bit m_lost;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] m_state();
    if (!m_locked) return (m_good == 0) ? 2'b00 : 2'b01;
    return (m_bad == 0) ? 2'b10 : 2'b11;
  endfunction

  function automatic logic [11:0] m_pack();
    return {m_lost, 8'(m_slip), m_locked, m_state()};
  endfunction

  task automatic model_reset();
    m_locked = 0; m_good = 0; m_bad = 0; m_slip = 0; m_lost = 0;
  endtask

  task automatic model_sample(input int mag, input int thr, input int n);
    int nn;
    nn = (n == 0) ? 1 : n;
    m_lost = 0;
    if (!m_locked) begin
      if (mag <= thr) begin
        m_good++;
        if (m_good >= nn) begin m_locked = 1; m_good = 0; m_bad = 0; end
      end else begin
        m_good = 0;
      end
    end else if (mag <= thr) begin
      m_bad = 0;
    end else begin
      m_bad++;
      if (m_bad >= UNLOCK_N) begin
        m_locked = 0; m_bad = 0; m_good = 0;
        if (m_slip < 255) m_slip++;
      end
    end
  endtask

  task automatic model_timeout();
    if (m_locked && m_slip < 255) m_slip++;
    m_locked = 0; m_good = 0; m_bad = 0; m_lost = 1;
  endtask

  // ---------------- driver ----------------
  // Called on a negedge; returns on a negedge three cycles after the strobe.
  task automatic send(input int mag, input int thr, input int n, input bit do_clr);
    int lat;
    lat = 0;
    bus.err_mag  = 5'(mag);
    bus.lock_thr = 5'(thr);
    bus.lock_n   = 4'(n);
    bus.err_sign = 1'($urandom_range(0, 1));
    bus.clk_ref  = 1'b1;
    if (do_clr) model_reset(); else model_sample(mag, thr, n);
    exp_q.push_back(m_pack());
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      if (bus.sample_stb) begin lat = i; break; end
    end
    check("stb_latency", lat, 3);
    bus.clr     = do_clr;
    bus.clk_ref = 1'b0;
    @(negedge clk);
    bus.clr = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic idle_gap(input int cycles);
    repeat (cycles) @(negedge clk);
    if (cycles >= TIMEOUT - 2) model_timeout();
    check("idle_lost", bus.ref_lost, m_lost);
    check("idle_state", bus.lock_state, m_state());
    check("idle_slip", bus.slip_cnt, m_slip);
  endtask

  task automatic do_reset();
    #3 rst_n = 1'b0;
    #1;
    check("rst_state", bus.lock_state, 0);
    check("rst_locked", bus.locked, 0);
    check("rst_lost", bus.ref_lost, 0);
    check("rst_slip", bus.slip_cnt, 0);
    check("rst_stb", bus.sample_stb, 0);
    check("rst_queue_empty", exp_q.size(), 0);
    model_reset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // ---------------- monitor ----------------
  initial begin : monitor
    logic [11:0] e;
    forever begin
      @(negedge clk);
      if (rst_n && bus.sample_stb) begin
        @(negedge clk);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_stb got=strobe exp=none");
        end else begin
          e = exp_q.pop_front();
          check("sample_resp", {bus.ref_lost, bus.slip_cnt, bus.locked, bus.lock_state}, e);
        end
      end
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    int thr, n, mag;
    bit c;
    bus.clk_ref = 1'b0; bus.clr = 1'b0; bus.err_mag = '0; bus.err_sign = 1'b0;
    bus.lock_thr = '0; bus.lock_n = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check("reset_state", bus.lock_state, 0);
    check("reset_slip", bus.slip_cnt, 0);
    check("reset_stb", bus.sample_stb, 0);
    rst_n = 1'b1;

    // acquire with N=4: 01,01,01,10
    repeat (4) send(2, 3, 4, 0);
    // HOLD three times then back to LOCKED
    repeat (3) send(9, 3, 4, 0);
    send(0, 3, 4, 0);

    // reference loss while LOCKED, exact boundary
    repeat (TIMEOUT - 3) @(negedge clk);
    check("pre_timeout_lost", bus.ref_lost, 0);
    check("pre_timeout_state", bus.lock_state, m_state());
    @(negedge clk);
    model_timeout();
    check("timeout_lost", bus.ref_lost, 1);
    check("timeout_state", bus.lock_state, 0);
    check("timeout_slip", bus.slip_cnt, m_slip);
    send(0, 3, 4, 0);             // ref_lost clears, sample counts
    repeat (3) send(0, 3, 4, 0);  // relock

    // lose lock, then saturate slip_cnt
    repeat (4) send(9, 3, 4, 0);
    for (int i = 0; i < 300; i++) begin
      send(0, 5, 0, 0);
      repeat (4) send(9, 3, 4, 0);
    end
    check("slip_saturated", bus.slip_cnt, 255);

    // clr coincident with a strobe in HOLD; the sample is dropped
    send(0, 5, 0, 0);
    send(9, 3, 4, 0);
    send(0, 5, 0, 1);

    // lock_n=0, err_mag == lock_thr locks on one sample
    send(5, 5, 0, 0);

    // reset in LOCKED with a non-zero slip count
    repeat (4) send(9, 3, 4, 0);
    send(1, 3, 1, 0);
    do_reset();

    // lowering lock_n mid-acquisition
    repeat (3) send(1, 3, 8, 0);
    send(1, 3, 2, 0);
    repeat (4) send(20, 3, 2, 0);
    repeat (2) send(1, 3, 8, 0);
    do_reset();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      thr = $urandom_range(0, 31);
      n   = ($urandom_range(0, 9) == 0) ? $urandom_range(7, 15) : $urandom_range(0, 5);
      mag = ($urandom_range(0, 9) < 7) ? $urandom_range(0, thr) : $urandom_range(0, 31);
      c   = ($urandom_range(0, 39) == 0);
      send(mag, thr, n, c);
      if (i % 150 == 75) idle_gap(1100);
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    check("queue_drained", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
